// File: rtl/alu_mul_sequencer_pkg.sv
// Shared constants for the ALU-borrowing multiply sequencer: ALU control codes
// and the sequencer state encoding.
package alu_mul_sequencer_pkg;

  localparam logic [3:0] ALU_AND    = 4'd0;
  localparam logic [3:0] ALU_OR     = 4'd1;
  localparam logic [3:0] ALU_ADD    = 4'd2;
  localparam logic [3:0] ALU_MUL    = 4'd3;
  localparam logic [3:0] ALU_SUB    = 4'd6;
  localparam logic [3:0] ALU_SLT    = 4'd7;
  localparam logic [3:0] ALU_BNE    = 4'd8;
  localparam logic [3:0] ALU_SRA    = 4'd9;
  localparam logic [3:0] ALU_SRAV   = 4'd11;
  localparam logic [3:0] ALU_NOR    = 4'd12;
  localparam logic [3:0] ALU_SLTU16 = 4'd13;
  localparam logic [3:0] ALU_LUI    = 4'd14;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/alu_mul_sequencer.sv
// Unsigned WIDTHxWIDTH shift-and-add multiplier that borrows the shared ALU
// adder for one iteration per cycle while alu_own_o is high.
module alu_mul_sequencer
  import alu_mul_sequencer_pkg::*;
#(
  parameter int         WIDTH    = 32,
  parameter logic [3:0] CTRL_ADD = ALU_ADD,
  parameter int         CNT_W    = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] mcand_i,
  input  logic [WIDTH-1:0] mplier_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             alu_own_o,
  output logic [WIDTH-1:0] alu_src1_o,
  output logic [WIDTH-1:0] alu_src2_o,
  output logic [3:0]       alu_ctrl_o,
  input  logic [WIDTH-1:0] alu_result_i
);

  seq_state_t       state;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] mcand;
  logic [CNT_W-1:0] cnt;
  logic             busy;
  logic             done;
  logic             own;
  logic             carry;

  // Operands are decoded straight from registers so the ALU sees them at the
  // start of each RUN cycle; outside RUN they are forced to zero.
  assign alu_src1_o = (state == RUN) ? hi : '0;
  assign alu_src2_o = ((state == RUN) && lo[0]) ? mcand : '0;
  assign alu_ctrl_o = CTRL_ADD;

  // The ALU has no carry-out, so recover it from unsigned wrap-around.
  assign carry = (alu_result_i < alu_src1_o);

  assign hi_o      = hi;
  assign lo_o      = lo;
  assign busy_o    = busy;
  assign done_o    = done;
  assign alu_own_o = own;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
      hi    <= '0;
      lo    <= '0;
      mcand <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      own   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            mcand <= mcand_i;
            lo    <= mplier_i;
            hi    <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            own   <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          hi <= {carry, alu_result_i[WIDTH-1:1]};
          lo <= {alu_result_i[0], lo[WIDTH-1:1]};
          // Counter holds on the final iteration so it never wraps.
          if (cnt == CNT_W'(WIDTH - 1)) begin
            own   <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          own   <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench for alu_mul_sequencer with a behavioural shared ALU wired to
// the sequencer's alu_* ports.
module tb_alu_mul_sequencer;
  import alu_mul_sequencer_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic        busy_o;
  logic        done_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        alu_own_o;
  logic [31:0] alu_src1_o;
  logic [31:0] alu_src2_o;
  logic [3:0]  alu_ctrl_o;
  logic [31:0] alu_result;

  int checks   = 0;
  int failures = 0;

  alu_mul_sequencer dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .mcand_i     (mcand),
    .mplier_i    (mplier),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .hi_o        (hi_o),
    .lo_o        (lo_o),
    .alu_own_o   (alu_own_o),
    .alu_src1_o  (alu_src1_o),
    .alu_src2_o  (alu_src2_o),
    .alu_ctrl_o  (alu_ctrl_o),
    .alu_result_i(alu_result)
  );

  // Shared combinational ALU, as seen by the CPU datapath.
  always_comb begin
    alu_result = '0;
    case (alu_ctrl_o)
      ALU_AND: alu_result = alu_src1_o & alu_src2_o;
      ALU_OR:  alu_result = alu_src1_o | alu_src2_o;
      ALU_ADD: alu_result = alu_src1_o + alu_src2_o;
      ALU_SUB: alu_result = alu_src1_o - alu_src2_o;
      ALU_NOR: alu_result = ~(alu_src1_o | alu_src2_o);
      ALU_LUI: alu_result = {alu_src2_o[15:0], 16'h0000};
      default: alu_result = '0;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Pulses start for one cycle, then waits (bounded) for done_o and reports
  // latency from the start cycle, busy cycles and nonzero operand-2 cycles.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               output int lat, output int busy_cnt,
                               output int src2_hits, output logic own_at_done);
    @(negedge clk);
    start = 1'b1; mcand = a; mplier = b;
    lat = -1; busy_cnt = 0; src2_hits = 0; own_at_done = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy_o) busy_cnt++;
      if (alu_own_o && alu_src2_o != 32'h0) src2_hits++;
      if (done_o) begin
        lat = i;
        own_at_done = alu_own_o;
        break;
      end
    end
  endtask

  initial begin
    int   lat;
    int   busy_cnt;
    int   src2_hits;
    int   bad;
    logic own_at_done;

    rst = 1'b1; start = 1'b0; mcand = '0; mplier = '0;
    #1 rst = 1'b0;
    #3;
    checkOutput("reset_flags", {61'd0, busy_o, done_o, alu_own_o}, 64'd0);
    checkOutput("reset_srcs", {alu_src1_o, alu_src2_o}, 64'd0);
    checkOutput("reset_ctrl", {60'd0, alu_ctrl_o}, {60'd0, ALU_ADD});
    checkOutput("reset_prod", {hi_o, lo_o}, 64'd0);
    @(negedge clk) rst = 1'b1;

    // 3 x 5
    applyStimulus(32'd3, 32'd5, lat, busy_cnt, src2_hits, own_at_done);
    checkOutput("lat_3x5", 64'(lat), 64'd33);
    checkOutput("busy_3x5", 64'(busy_cnt), 64'd33);
    checkOutput("prod_3x5", {hi_o, lo_o}, 64'h00000000_0000000F);
    checkOutput("own_done_3x5", {63'd0, own_at_done}, 64'd0);
    @(negedge clk);
    checkOutput("done_pulse", {62'd0, done_o, busy_o}, 64'd0);

    // Idle hold with start low
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (hi_o != 32'h0 || lo_o != 32'hF || alu_src1_o != 32'h0 ||
          alu_src2_o != 32'h0 || busy_o || alu_own_o) bad++;
    end
    checkOutput("idle_stable", 64'(bad), 64'd0);

    applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, lat, busy_cnt, src2_hits, own_at_done);
    checkOutput("lat_ff", 64'(lat), 64'd33);
    checkOutput("prod_ff", {hi_o, lo_o}, 64'hFFFFFFFE_00000001);

    applyStimulus(32'h80000000, 32'd2, lat, busy_cnt, src2_hits, own_at_done);
    checkOutput("prod_msb", {hi_o, lo_o}, 64'h00000001_00000000);

    applyStimulus(32'h1234, 32'd0, lat, busy_cnt, src2_hits, own_at_done);
    checkOutput("prod_zero", {hi_o, lo_o}, 64'd0);
    checkOutput("src2_zero", 64'(src2_hits), 64'd0);
    checkOutput("lat_zero", 64'(lat), 64'd33);

    // start held high with operands changing during RUN
    @(negedge clk);
    start = 1'b1; mcand = 32'd7; mplier = 32'd6;
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (done_o) begin
        lat = i;
        break;
      end
      mcand = mcand + 32'h101;
      mplier = mplier ^ 32'h55;
    end
    checkOutput("held_lat", 64'(lat), 64'd33);
    checkOutput("held_prod", {hi_o, lo_o}, 64'd42);
    checkOutput("held_own_done", {63'd0, alu_own_o}, 64'd0);
    @(negedge clk);
    checkOutput("held_idle", {62'd0, busy_o, alu_own_o}, 64'd0);
    checkOutput("held_idle_hold", {hi_o, lo_o}, 64'd42);
    mcand = 32'd9; mplier = 32'd11;
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done_o) begin
        lat = i;
        break;
      end
    end
    checkOutput("held_lat2", 64'(lat), 64'd33);
    checkOutput("held_prod2", {hi_o, lo_o}, 64'd99);

    // Asynchronous reset in the middle of iteration 10
    @(negedge clk);
    start = 1'b1; mcand = 32'hABCD; mplier = 32'h1111;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 9; i++) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checkOutput("abort_flags", {61'd0, busy_o, done_o, alu_own_o}, 64'd0);
    checkOutput("abort_prod", {hi_o, lo_o}, 64'd0);
    checkOutput("abort_srcs", {alu_src1_o, alu_src2_o}, 64'd0);
    @(negedge clk) rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_o || busy_o) bad++;
    end
    checkOutput("abort_no_done", 64'(bad), 64'd0);
    applyStimulus(32'h0000FFFF, 32'h0000FFFF, lat, busy_cnt, src2_hits, own_at_done);
    checkOutput("after_abort_lat", 64'(lat), 64'd33);
    checkOutput("after_abort_prod", {hi_o, lo_o}, 64'h00000000_FFFE0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
